// File: rtl/mem_initiator.sv
// Burst initiator for the single-port byte memory. It accepts write and read burst commands.
// Write beats are streamed into the memory, and read beats come back under rd_ready backpressure.
module mem_initiator #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_HOLD = 2'd3;

    localparam int                WAIT_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [LEN_W-1:0]  beats_left;
    logic [WAIT_W-1:0] wait_cnt;
    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_fire;
    logic              rd_sample;

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign wr_ready  = (state == ST_WRITE) && !rst;
    assign busy      = (state != ST_IDLE);

    // Handshake qualifiers shared by the control, memory-side and read-side registers.
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = (state == ST_RD_HOLD) && rd_valid && rd_ready;
    assign rd_sample = (state == ST_RD_WAIT) && (wait_cnt == WAIT_ZERO);
    assign addr_inc  = addr + ADDR_ONE;

    // Burst control: state, running address, remaining beats and read-latency countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr       <= ADDR_ZERO;
            beats_left <= LEN_ZERO;
            wait_cnt   <= WAIT_ZERO;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        addr       <= cmd_addr;
                        beats_left <= cmd_len;
                        if (cmd_write) begin
                            state <= ST_WRITE;
                        end else begin
                            state    <= ST_RD_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_fire) begin
                        addr <= addr_inc;
                        if (beats_left == LEN_ZERO) begin
                            state <= ST_IDLE;
                        end else begin
                            beats_left <= beats_left - LEN_ONE;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // The count reaches zero exactly when the memory output is valid.
                    if (wait_cnt == WAIT_ZERO) begin
                        state <= ST_RD_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                ST_RD_HOLD: begin
                    if (rd_fire) begin
                        if (rd_last) begin
                            state <= ST_IDLE;
                        end else begin
                            addr       <= addr_inc;
                            beats_left <= beats_left - LEN_ONE;
                            wait_cnt   <= WAIT_LOAD;
                            state      <= ST_RD_WAIT;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory bus: single-cycle read/write strobes with their address and write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_address  <= ADDR_ZERO;
            mem_data_in  <= DATA_ZERO;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
        end else begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            if (cmd_fire && !cmd_write) begin
                mem_address <= cmd_addr;
                mem_read_en <= 1'b1;
            end else if (wr_fire) begin
                mem_address  <= addr;
                mem_data_in  <= wr_data;
                mem_write_en <= 1'b1;
            end else if (rd_fire && !rd_last) begin
                mem_address <= addr_inc;
                mem_read_en <= 1'b1;
            end else begin
                mem_address <= mem_address;
            end
        end
    end

    // Read return: capture memory data and hold it stable until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= DATA_ZERO;
            rd_last  <= 1'b0;
        end else begin
            if (rd_sample) begin
                rd_data  <= mem_data_out;
                rd_valid <= 1'b1;
                rd_last  <= (beats_left == LEN_ZERO);
            end else if (rd_fire) begin
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_valid;
            end
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator. It uses a byte-memory model and a transaction-level scoreboard.
// It also runs directed bursts with hand-computed expectations.
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready, rd_last, busy;
    logic [7:0] rd_data;
    logic [7:0] mem_address, mem_data_in, mem_data_out;
    logic       mem_read_en, mem_write_en;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_initiator #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out)
    );

    // Memory wrapper with one cycle of read latency.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address] <= mem_data_in;
        if (mem_read_en) mem_data_out <= mem[mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state.
    logic [7:0]  ref_mem [0:255];
    logic [15:0] exp_wr_q[$];
    logic [8:0]  exp_rd_q[$];
    logic [15:0] wr_log[$];
    logic [8:0]  rd_log[$];
    int          rd_hs_cyc[$];
    int          m_wr_left = 0;
    logic [7:0]  m_addr = 8'd0;
    int          n_wstrobe = 0;
    int          last_rd_cyc = 0;
    int          cmd_acc_cyc = 0;

    initial begin : monitor
        logic [15:0] ew;
        logic [8:0]  er;
        logic [7:0]  a;
        logic        prev_stall;
        logic [7:0]  prev_data;
        logic        prev_last;
        logic        m_busy;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_wr_q.delete();
                exp_rd_q.delete();
                m_wr_left  = 0;
                prev_stall = 1'b0;
            end else begin
                m_busy = (m_wr_left != 0) || (exp_rd_q.size() != 0);
                check("busy", 32'(busy), 32'(m_busy));
                check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
                check("wr_ready", 32'(wr_ready), 32'(m_wr_left != 0));
                check("strobe_excl", 32'(mem_read_en && mem_write_en), 32'd0);
                check("rden_while_rdvalid", 32'(mem_read_en && rd_valid), 32'd0);
                if (prev_stall) begin
                    check("stall_valid", 32'(rd_valid), 32'd1);
                    check("stall_data", 32'(rd_data), 32'(prev_data));
                    check("stall_last", 32'(rd_last), 32'(prev_last));
                end
                if (mem_write_en) begin
                    n_wstrobe++;
                    wr_log.push_back({mem_address, mem_data_in});
                    if (exp_wr_q.size() == 0) begin
                        check("write_expected", 32'd0, 32'd1);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        check("wr_addr", 32'(mem_address), 32'(ew[15:8]));
                        check("wr_data", 32'(mem_data_in), 32'(ew[7:0]));
                    end
                end
                if (rd_valid && rd_ready) begin
                    rd_log.push_back({rd_last, rd_data});
                    rd_hs_cyc.push_back(cyc);
                    if (rd_last) last_rd_cyc = cyc;
                    if (exp_rd_q.size() == 0) begin
                        check("read_expected", 32'd0, 32'd1);
                    end else begin
                        er = exp_rd_q.pop_front();
                        check("rd_data", 32'(rd_data), 32'(er[7:0]));
                        check("rd_last", 32'(rd_last), 32'(er[8]));
                    end
                end
                prev_stall = rd_valid && !rd_ready;
                prev_data  = rd_data;
                prev_last  = rd_last;
                if (cmd_valid && cmd_ready) begin
                    cmd_acc_cyc = cyc;
                    m_addr = cmd_addr;
                    if (cmd_write) begin
                        m_wr_left = int'(cmd_len) + 1;
                    end else begin
                        a = cmd_addr;
                        for (int i = 0; i <= int'(cmd_len); i++) begin
                            exp_rd_q.push_back({(i == int'(cmd_len)), ref_mem[a]});
                            a = a + 8'd1;
                        end
                    end
                end
                if (wr_valid && wr_ready) begin
                    exp_wr_q.push_back({m_addr, wr_data});
                    ref_mem[m_addr] = wr_data;
                    m_addr = m_addr + 8'd1;
                    m_wr_left--;
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] l);
        logic got;
        got = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        check("cmd_accepted", 32'(got), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_wr(input logic [7:0] d, input int gap);
        logic got;
        got = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        wr_valid = 1'b1; wr_data = d;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wr_ready) begin got = 1'b1; break; end
        end
        check("wr_accepted", 32'(got), 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && exp_rd_q.size() == 0 && exp_wr_q.size() == 0) begin got = 1'b1; break; end
        end
        check("idle_reached", 32'(got), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [15:0] exp_wrap [4] = '{16'hFE01, 16'hFF02, 16'h0003, 16'h0104};
    logic [8:0]  exp_bp   [3] = '{9'h011, 9'h022, 9'h133};
    logic [8:0]  exp_blk  [3] = '{9'h011, 9'h122, 9'h1A5};

    initial begin : stimulus
        int ws0;
        logic got;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'd0; cmd_len = 4'd0;
        wr_valid = 1'b0; wr_data = 8'd0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_ctl", 32'({mem_read_en, mem_write_en, rd_valid, rd_last}), 32'd0);
        check("rst_mem_bus", 32'({mem_address, mem_data_in, rd_data}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Single write
        send_cmd(1'b1, 8'h10, 4'd0);
        send_wr(8'hA5, 0);
        @(negedge clk);
        check("single_we", 32'(mem_write_en), 32'd1);
        check("single_addr", 32'(mem_address), 32'h10);
        check("single_data", 32'(mem_data_in), 32'hA5);
        check("single_busy", 32'(busy), 32'd0);
        check("single_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("single_we_drop", 32'(mem_write_en), 32'd0);
        @(posedge clk); #1;

        // Read-back latency
        send_cmd(1'b1, 8'h20, 4'd0);
        send_wr(8'h3C, 0);
        wait_idle();
        send_cmd(1'b0, 8'h20, 4'd0);
        @(negedge clk);
        check("rb_re", 32'(mem_read_en), 32'd1);
        check("rb_addr", 32'(mem_address), 32'h20);
        check("rb_valid_early", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("rb_re_drop", 32'(mem_read_en), 32'd0);
        check("rb_valid_early2", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("rb_valid", 32'(rd_valid), 32'd1);
        check("rb_data", 32'(rd_data), 32'h3C);
        check("rb_last", 32'(rd_last), 32'd1);
        @(posedge clk); #1;
        wait_idle();

        // Gapped write burst wrapping past 0xFF
        wr_log.delete();
        ws0 = n_wstrobe;
        send_cmd(1'b1, 8'hFE, 4'd3);
        for (int i = 1; i <= 4; i++) send_wr(8'(i), 1);
        wait_idle();
        check("wrap_strobes", 32'(n_wstrobe - ws0), 32'd4);
        check("wrap_log_size", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check("wrap_entry", 32'(wr_log[i]), 32'(exp_wrap[i]));

        // Read burst with backpressure on the first beat
        send_cmd(1'b1, 8'h40, 4'd2);
        send_wr(8'h11, 0);
        send_wr(8'h22, 0);
        send_wr(8'h33, 0);
        wait_idle();
        rd_log.delete();
        rd_hs_cyc.delete();
        rd_ready = 1'b0;
        send_cmd(1'b0, 8'h40, 4'd2);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_valid) begin got = 1'b1; break; end
        end
        check("bp_first_valid", 32'(got), 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_idle();
        check("bp_beats", 32'(rd_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < rd_log.size(); i++)
            check("bp_entry", 32'(rd_log[i]), 32'(exp_bp[i]));
        if (rd_hs_cyc.size() == 3)
            check("bp_throughput", 32'(rd_hs_cyc[2] - rd_hs_cyc[1]), 32'd3);
        else
            check("bp_hs_count", 32'(rd_hs_cyc.size()), 32'd3);

        // Command held during a read burst
        rd_log.delete();
        send_cmd(1'b0, 8'h40, 4'd1);
        send_cmd(1'b0, 8'h10, 4'd0);
        check("blk_accept_gap", 32'(cmd_acc_cyc - last_rd_cyc), 32'd1);
        wait_idle();
        check("blk_beats", 32'(rd_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < rd_log.size(); i++)
            check("blk_entry", 32'(rd_log[i]), 32'(exp_blk[i]));

        // Reset in the middle of a write burst
        send_cmd(1'b1, 8'h60, 4'd3);
        send_wr(8'h77, 0);
        @(posedge clk); #1;
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h88;
        @(posedge clk); #1;
        rst = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mr_wr_ready", 32'(wr_ready), 32'd0);
        check("mr_ctl", 32'({mem_read_en, mem_write_en, rd_valid, rd_last}), 32'd0);
        check("mr_bus", 32'({mem_address, mem_data_in, rd_data}), 32'd0);
        @(posedge clk); #1;
        send_cmd(1'b1, 8'h61, 4'd0);
        send_wr(8'h99, 0);
        wait_idle();
        rd_log.delete();
        send_cmd(1'b0, 8'h60, 4'd1);
        wait_idle();
        check("mr_beats", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() == 2) begin
            check("mr_beat0", 32'(rd_log[0]), 32'h077);
            check("mr_beat1", 32'(rd_log[1]), 32'h199);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
